// File: rtl/instruction_fetch_unit.sv
// Program counter and IF/ID stage: drives the instruction memory address, captures the fetched
// word into a valid/ready slot and services redirects. Define FETCH_ALIGN_CHECK_EN to trap misaligned redirects.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instruction,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        fault,
    output logic [31:0] fault_pc
);

    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        valid_next;
    logic [31:0] instruction_next;
    logic [31:0] id_pc_next;
    logic [31:0] id_pc_plus4_next;
    logic [31:0] fetch_count_next;
    logic        slot_free;
    logic        in_run;
    logic        misaligned;

    assign imem_address = pc;
    assign slot_free    = !id_valid || id_ready;

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] fault_pc_reg;
    logic [31:0] fault_pc_next;

    assign in_run     = (state == RUN);
    assign misaligned = (redirect_pc[1:0] != 2'b00);
    assign fault      = (state == FAULT);
    assign fault_pc   = fault_pc_reg;

    always_comb begin
        state_next    = state;
        fault_pc_next = fault_pc_reg;
        case (state)
            RUN: begin
                if (redirect_valid && misaligned) begin
                    state_next    = FAULT;
                    fault_pc_next = redirect_pc;
                end
            end
            FAULT:   state_next = FAULT;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            fault_pc_reg <= 32'h0;
        end else begin
            state        <= state_next;
            fault_pc_reg <= fault_pc_next;
        end
    end
`else
    // Without the trap every redirect target is silently word-aligned on load.
    assign in_run     = 1'b1;
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
    assign fault_pc   = 32'h0;
`endif

    always_comb begin
        // NOTE: every next-value gets a hold default first so no path leaves it unassigned (no latch).
        pc_next          = pc;
        valid_next       = id_valid;
        instruction_next = id_instruction;
        id_pc_next       = id_pc;
        id_pc_plus4_next = id_pc_plus4;
        fetch_count_next = fetch_count;
        if (in_run) begin
            if (redirect_valid) begin
                // Decode may still consume the old slot this cycle; the flush lands afterwards.
                valid_next       = 1'b0;
                instruction_next = NOP_WORD;
                if (!misaligned) begin
                    pc_next = redirect_pc & 32'hFFFF_FFFC;
                end
            end else if (slot_free) begin
                valid_next       = 1'b1;
                instruction_next = imem_instruction;
                id_pc_next       = pc;
                id_pc_plus4_next = pc + 32'd4;
                pc_next          = pc + 32'd4;
                fetch_count_next = fetch_count + 32'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            id_valid       <= 1'b0;
            id_instruction <= NOP_WORD;
            id_pc          <= 32'h0;
            id_pc_plus4    <= 32'h0;
            fetch_count    <= 32'h0;
        end else begin
            pc             <= pc_next;
            id_valid       <= valid_next;
            id_instruction <= instruction_next;
            id_pc          <= id_pc_next;
            id_pc_plus4    <= id_pc_plus4_next;
            fetch_count    <= fetch_count_next;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan cases pinned with literals,
// then randomized traffic compared every cycle against a behavioural model of the fetch slot.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] fetch_count;
    logic        fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_id_pc;
    logic [31:0] m_plus4;
    logic [31:0] m_count;
    logic        m_fault;
    logic [31:0] m_fault_pc;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_C0DE;
    endfunction

    assign imem_instruction = mem_word(imem_address);

    instruction_fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .imem_address     (imem_address),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .id_ready         (id_ready),
        .id_valid         (id_valid),
        .id_instruction   (id_instruction),
        .id_pc            (id_pc),
        .id_pc_plus4      (id_pc_plus4),
        .fetch_count      (fetch_count),
        .fault            (fault),
        .fault_pc         (fault_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        bit trap_enabled;
`ifdef FETCH_ALIGN_CHECK_EN
        trap_enabled = 1'b1;
`else
        trap_enabled = 1'b0;
`endif
        if (r) begin
            m_pc = 32'h0; m_valid = 1'b0; m_instr = NOP; m_id_pc = 32'h0;
            m_plus4 = 32'h0; m_count = 32'h0; m_fault = 1'b0; m_fault_pc = 32'h0;
        end else if (m_fault) begin
            // trapped: everything frozen until reset
        end else if (rv) begin
            m_valid = 1'b0;
            m_instr = NOP;
            if (trap_enabled && (rpc % 4 != 0)) begin
                m_fault    = 1'b1;
                m_fault_pc = rpc;
            end else begin
                m_pc = rpc - (rpc % 4);
            end
        end else if (!m_valid || rdy) begin
            m_valid = 1'b1;
            m_instr = mem_word(m_pc);
            m_id_pc = m_pc;
            m_plus4 = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic compare();
        check("imem_address", imem_address, m_pc);
        check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
        check("id_instruction", id_instruction, m_instr);
        check("id_pc", id_pc, m_id_pc);
        check("id_pc_plus4", id_pc_plus4, m_plus4);
        check("fetch_count", fetch_count, m_count);
        check("fault", {31'b0, fault}, {31'b0, m_fault});
        check("fault_pc", fault_pc, m_fault_pc);
    endtask

    // Drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
        reset = r; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
        @(posedge clk);
        model_step(r, rv, rpc, rdy);
        @(negedge clk);
        compare();
    endtask

    initial begin
        logic [31:0] count_before;
        logic [31:0] rpc;
        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        @(negedge clk);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("reset imem_address", imem_address, 32'h0);
        check("reset id_valid", {31'b0, id_valid}, 32'h0);
        check("reset id_instruction", id_instruction, 32'h0000_0013);
        check("reset fetch_count", fetch_count, 32'h0);

        // Fill: id_pc 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check("fill id_pc", id_pc, 32'(4 * i));
        end
        check("first word", id_instruction, mem_word(32'h8));
        // Stall three cycles with id_pc = 8
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check("stall id_pc", id_pc, 32'h8);
            check("stall imem_address", imem_address, 32'hC);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("release id_pc", id_pc, 32'hC);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("id_pc 10", id_pc, 32'h10);
        check("five captures", fetch_count, 32'd5);

        // Mid-stream reset at id_pc = 10
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("midreset valid", {31'b0, id_valid}, 32'h0);
        check("midreset imem_address", imem_address, 32'h0);
        check("midreset id_pc", id_pc, 32'h0);
        check("midreset count", fetch_count, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("restart id_pc", id_pc, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect to 0x40 with a valid slot being consumed
        count_before = fetch_count;
        cycle(1'b0, 1'b1, 32'h40, 1'b1);
        check("redirect flush valid", {31'b0, id_valid}, 32'h0);
        check("redirect imem_address", imem_address, 32'h40);
        check("redirect count held", fetch_count, count_before);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("redirect target id_pc", id_pc, 32'h40);
        check("redirect count", fetch_count, count_before + 32'd1);

        // PC wrap
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap id_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap plus4", id_pc_plus4, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrapped id_pc", id_pc, 32'h0);

        // Misaligned redirect
        cycle(1'b0, 1'b1, 32'h42, 1'b1);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'($urandom), $urandom, 1'($urandom));
            check("trap fault", {31'b0, fault}, 32'h1);
            check("trap fault_pc", fault_pc, 32'h42);
            check("trap valid", {31'b0, id_valid}, 32'h0);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        check("trap cleared", {31'b0, fault}, 32'h0);
`else
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("aligned id_pc", id_pc, 32'h40);
        check("no fault", {31'b0, fault}, 32'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
            if ($urandom_range(0, 19) != 0) rpc[1:0] = 2'b00;
`endif
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), rpc,
                  ($urandom_range(0, 9) < 7));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
